// File: rtl/krnl_cam_rtl_pkg.sv
// Shared definitions for the CAM command scheduler: requester opcodes,
// the CAM FSM idle code and the scheduler state encoding.
package krnl_cam_rtl_pkg;

    typedef enum logic [1:0] {
        OP_INVALID    = 2'd0,
        OP_UPDATE_ALL = 2'd1,
        OP_SEARCH     = 2'd2,
        OP_UPDATE_ONE = 2'd3
    } cam_op_e;

    localparam int unsigned CAM_IDLE_CODE = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RESP
    } sched_state_e;

    // Command-select nibble of the CAM data word: bit[op] set.
    function automatic logic [3:0] op_onehot(input cam_op_e op);
        logic [3:0] oh;
        oh     = 4'b0000;
        oh[op] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/krnl_cam_rtl_rr_arb.sv
// Two-requester round-robin arbiter; the pointer names the preferred
// requester and flips to the other one whenever a grant is issued.
module krnl_cam_rtl_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i[ptr_q]) begin
            gnt_o[ptr_q] = 1'b1;
        end else if (req_i[~ptr_q]) begin
            gnt_o[~ptr_q] = 1'b1;
        end
    end

    assign ptr_d = (|gnt_o) ? ~gnt_o[1] : ptr_q;

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/krnl_cam_rtl_cmd_sched.sv
// CAM command scheduler: arbitrates two requesters, issues one command word to
// the CAM FSM, tracks its state handshake with a timeout and reports completion.
module krnl_cam_rtl_cmd_sched
    import krnl_cam_rtl_pkg::*;
#(
    parameter int C_DATA_WIDTH   = 512,
    parameter int OP_CODE_WIDTH  = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [3:0]               req_op,
    input  logic [63:0]              req_arg,
    output logic [C_DATA_WIDTH-1:0]  cam_data,
    input  logic [OP_CODE_WIDTH-1:0] cam_state,
    output logic                     resp_valid,
    output logic                     resp_id,
    output logic                     resp_err,
    output logic                     resp_timeout,
    output logic [31:0]              resp_cycles,
    output logic                     busy
);

    sched_state_e state_q, state_d;
    cam_op_e      op_q, op_d;
    logic         id_q, id_d;
    logic [31:0]  arg_q, arg_d;
    logic         err_q, err_d;
    logic         to_q, to_d;
    logic [31:0]  cnt_q, cnt_d;

    logic [1:0]   arb_req;
    logic [1:0]   arb_gnt;
    logic         handshake;
    logic         gnt_id;
    logic [1:0]   sel_op;
    logic [31:0]  sel_arg;
    logic [31:0]  cnt_inc;
    logic         timeout_hit;
    logic         cam_idle;

    // Requests are only presented to the arbiter while idle and out of reset,
    // which keeps exactly one command in flight.
    assign arb_req = (rst_n && (state_q == S_IDLE)) ? req_valid : 2'b00;

    krnl_cam_rtl_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (arb_req),
        .gnt_o (arb_gnt)
    );

    assign req_ready   = arb_gnt;
    assign handshake   = |arb_gnt;
    assign gnt_id      = arb_gnt[1];
    assign sel_op      = gnt_id ? req_op[3:2] : req_op[1:0];
    assign sel_arg     = gnt_id ? req_arg[63:32] : req_arg[31:0];
    assign cam_idle    = (cam_state == OP_CODE_WIDTH'(CAM_IDLE_CODE));
    assign cnt_inc     = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    assign timeout_hit = (cnt_inc >= 32'(TIMEOUT_CYCLES));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        id_d    = id_q;
        arg_d   = arg_q;
        err_d   = err_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    op_d    = cam_op_e'(sel_op);
                    id_d    = gnt_id;
                    arg_d   = sel_arg;
                    err_d   = (cam_op_e'(sel_op) == OP_INVALID);
                    to_d    = 1'b0;
                    cnt_d   = 32'd0;
                    state_d = (cam_op_e'(sel_op) == OP_INVALID) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = cnt_inc;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                cnt_d = cnt_inc;
                if (!cam_idle) begin
                    state_d = S_WAIT_DONE;
                end else if (timeout_hit) begin
                    to_d    = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT_DONE: begin
                cnt_d = cnt_inc;
                if (cam_idle) begin
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    to_d    = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_INVALID;
            id_q    <= 1'b0;
            arg_q   <= 32'd0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            id_q    <= id_d;
            arg_q   <= arg_d;
            err_q   <= err_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are also gated by rst_n so they drop in the very cycle reset is asserted.
    always_comb begin
        cam_data = '0;
        if (rst_n && (state_q == S_ISSUE)) begin
            cam_data[3:0]   = op_onehot(op_q);
            cam_data[63:32] = arg_q;
        end
    end

    assign resp_valid   = rst_n && (state_q == S_RESP);
    assign resp_id      = resp_valid & id_q;
    assign resp_err     = resp_valid & err_q;
    assign resp_timeout = resp_valid & to_q;
    assign resp_cycles  = resp_valid ? cnt_q : 32'd0;
    assign busy         = rst_n && (state_q != S_IDLE);

endmodule

// File: tb/tb_krnl_cam_rtl_cmd_sched.sv
// Directed bench for the CAM command scheduler with a small behavioural CAM FSM
// that can answer a command after a fixed delay or stay idle forever.
module tb_krnl_cam_rtl_cmd_sched;

    localparam int DW = 512;
    localparam int OW = 3;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [3:0]    req_op;
    logic [63:0]   req_arg;
    logic [DW-1:0] cam_data;
    logic [OW-1:0] cam_state;
    logic          resp_valid;
    logic          resp_id;
    logic          resp_err;
    logic          resp_timeout;
    logic [31:0]   resp_cycles;
    logic          busy;

    always #5 clk = ~clk;

    krnl_cam_rtl_cmd_sched #(
        .C_DATA_WIDTH   (DW),
        .OP_CODE_WIDTH  (OW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_arg      (req_arg),
        .cam_data     (cam_data),
        .cam_state    (cam_state),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_err     (resp_err),
        .resp_timeout (resp_timeout),
        .resp_cycles  (resp_cycles),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int op, input logic [31:0] arg);
        logic [DW-1:0] w;
        w         = '0;
        w[op]     = 1'b1;
        w[63:32]  = arg;
        return w;
    endfunction

    // CAM model: a command seen in cycle t moves cam_state to 2 in cycle t+1
    // and back to 0 after busy_len cycles in state 2.
    bit cam_respond = 1'b1;
    int busy_len    = 5;

    initial begin
        cam_state = '0;
        forever begin
            @(negedge clk);
            if (cam_data != '0 && cam_respond) begin
                @(negedge clk);
                cam_state = 3'd2;
                repeat (busy_len) @(negedge clk);
                cam_state = '0;
            end
        end
    end

    int            pulse_cnt  = 0;
    int            resp_cnt   = 0;
    int            busy_hi    = 0;
    int            ready_both = 0;
    int            ready_busy = 0;
    int            resp_leak  = 0;
    logic [DW-1:0] last_pulse = '0;
    int            grants[$];

    initial begin
        forever begin
            @(negedge clk);
            if (cam_data != '0) begin
                pulse_cnt++;
                last_pulse = cam_data;
            end
            if (resp_valid) resp_cnt++;
            else if (resp_id || resp_err || resp_timeout || resp_cycles != 32'd0) resp_leak++;
            if (busy) busy_hi++;
            if (req_ready == 2'b11) ready_both++;
            if (req_ready != 2'b00 && busy) ready_busy++;
            if (req_ready != 2'b00) grants.push_back(int'(req_ready[1]));
        end
    end

    task automatic issue(input int id, input logic [1:0] op, input logic [31:0] arg);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        req_op[2*id +: 2]   = op;
        req_arg[32*id +: 32] = arg;
        req_valid[id]        = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (req_ready[id]) seen = 1'b1;
        end
        check($sformatf("grant_req%0d", id), DW'(seen), DW'(1));
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_resp(output logic id, output logic err, output logic tmo, output logic [31:0] cyc);
        bit got;
        got = 1'b0;
        id  = 1'b0;
        err = 1'b0;
        tmo = 1'b0;
        cyc = 32'd0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                id  = resp_id;
                err = resp_err;
                tmo = resp_timeout;
                cyc = resp_cycles;
            end
        end
        check("resp_seen", DW'(got), DW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_id, r_err, r_to;
        logic [31:0] r_cyc;
        int          p0, r0, b0, g0;

        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = 4'h0;
        req_arg   = 64'h0;

        // Reset holds all outputs low even with both requesters valid.
        repeat (2) @(posedge clk); #1;
        req_valid = 2'b11;
        req_op    = 4'b1010;
        @(negedge clk);
        check("rst_ready",      DW'(req_ready),  DW'(0));
        check("rst_cam_data",   cam_data,        '0);
        check("rst_busy",       DW'(busy),       DW'(0));
        check("rst_resp_valid", DW'(resp_valid), DW'(0));
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle after reset release.
        p0 = pulse_cnt; r0 = resp_cnt; b0 = busy_hi;
        repeat (100) @(posedge clk);
        check("idle_pulses", DW'(pulse_cnt - p0), DW'(0));
        check("idle_resps",  DW'(resp_cnt - r0),  DW'(0));
        check("idle_busy",   DW'(busy_hi - b0),   DW'(0));

        // Req0 SEARCH: one ISSUE cycle, 1 ack cycle, 5 busy cycles.
        p0 = pulse_cnt;
        issue(0, 2'd2, 32'h0000_0010);
        wait_resp(r_id, r_err, r_to, r_cyc);
        check("search_pulses", DW'(pulse_cnt - p0), DW'(1));
        check("search_word",   last_pulse,          exp_word(2, 32'h0000_0010));
        check("search_id",     DW'(r_id),           DW'(0));
        check("search_err",    DW'(r_err),          DW'(0));
        check("search_to",     DW'(r_to),           DW'(0));
        check("search_cycles", DW'(r_cyc),          DW'(7));

        // Req1 invalid opcode: accepted, dropped with an error response.
        p0 = pulse_cnt; g0 = grants.size();
        issue(1, 2'd0, 32'h0000_0055);
        wait_resp(r_id, r_err, r_to, r_cyc);
        check("inv_pulses", DW'(pulse_cnt - p0),     DW'(0));
        check("inv_grants", DW'(grants.size() - g0), DW'(1));
        check("inv_err",    DW'(r_err),              DW'(1));
        check("inv_id",     DW'(r_id),               DW'(1));
        check("inv_to",     DW'(r_to),               DW'(0));

        // CAM never acknowledges: abort after TO cycles.
        cam_respond = 1'b0;
        issue(1, 2'd1, 32'hDEAD_BEEF);
        wait_resp(r_id, r_err, r_to, r_cyc);
        check("to_word",   last_pulse,  exp_word(1, 32'hDEAD_BEEF));
        check("to_flag",   DW'(r_to),   DW'(1));
        check("to_cycles", DW'(r_cyc),  DW'(TO));
        check("to_id",     DW'(r_id),   DW'(1));
        check("to_err",    DW'(r_err),  DW'(0));
        cam_respond = 1'b1;
        issue(0, 2'd3, 32'h0000_0003);
        wait_resp(r_id, r_err, r_to, r_cyc);
        check("after_to_flag",   DW'(r_to),  DW'(0));
        check("after_to_id",     DW'(r_id),  DW'(0));
        check("after_to_cycles", DW'(r_cyc), DW'(7));

        // Reset while the CAM is busy aborts silently.
        busy_len = 20;
        r0 = resp_cnt;
        issue(0, 2'd2, 32'h0000_0077);
        repeat (4) @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cam_data", cam_data,        '0);
        check("midrst_busy",     DW'(busy),       DW'(0));
        check("midrst_resp",     DW'(resp_valid), DW'(0));
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        check("midrst_no_resp", DW'(resp_cnt - r0), DW'(0));
        busy_len = 5;

        // Both requesters held valid: req0 first after reset, then alternate.
        g0 = grants.size(); p0 = pulse_cnt;
        @(posedge clk); #1;
        req_op    = 4'b1111;
        req_arg   = {32'hB0B0_0001, 32'hA0A0_0000};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_resp(r_id, r_err, r_to, r_cyc);
            check($sformatf("rr_id%0d", k),     DW'(r_id),  DW'(k % 2));
            check($sformatf("rr_cycles%0d", k), DW'(r_cyc), DW'(7));
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (5) @(posedge clk);
        check("rr_grants", DW'(grants.size() - g0), DW'(4));
        if (grants.size() >= g0 + 4) begin
            check("rr_first", DW'(grants[g0]),     DW'(0));
            check("rr_second", DW'(grants[g0 + 1]), DW'(1));
        end
        check("rr_pulses", DW'(pulse_cnt - p0), DW'(4));
        check("rr_word",   last_pulse,          exp_word(3, 32'hB0B0_0001));

        check("ready_onehot",    DW'(ready_both), DW'(0));
        check("ready_while_busy", DW'(ready_busy), DW'(0));
        check("resp_fields_zero", DW'(resp_leak),  DW'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
